// File: rtl/dsc_byp_in_fifo_pkg.sv
// dsc_byp_in_fifo_pkg: shared dma constants and types for the bypass-in descriptor FIFO
// Contents: cidx width, default descriptor width, packed {dsc, cidx} entry, output-stage states.
package dsc_byp_in_fifo_pkg;
    localparam int CIDX_W    = 16;
    localparam int DSC_W_DEF = 256;
    typedef struct packed {
        logic [DSC_W_DEF-1:0] dsc;
        logic [CIDX_W-1:0]    cidx;
    } dsc_entry_t;
    typedef enum logic {ST_EMPTY, ST_VALID} out_st_t;
endpackage

// File: rtl/dsc_byp_fifo_ram.sv
// dsc_byp_fifo_ram: simple dual-port DEPTH x W storage with registered read
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data registered out.
// Read-during-write to the same address returns the old contents.
module dsc_byp_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 272
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/dsc_byp_in_fifo.sv
// dsc_byp_in_fifo: first-word fall-through descriptor FIFO feeding the DMA bypass-in interface
// Ports: axi_aclk, axi_aresetn (async active-low); in_dsc/in_cidx/in_vld/in_rdy upstream;
//        out_dsc/out_cidx/out_vld/out_rdy bypass-in master; flush; fill_lvl;
//        perf_push_cnt/perf_stall_cnt (live only when DSC_BYP_IN_PERF_CNT_EN is defined, else 0).
// Storage is a registered-read RAM plus the output register; fill_lvl counts both.
module dsc_byp_in_fifo
    import dsc_byp_in_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DSC_W = DSC_W_DEF
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,
    input  logic [DSC_W-1:0]         in_dsc,
    input  logic [CIDX_W-1:0]        in_cidx,
    input  logic                     in_vld,
    output logic                     in_rdy,
    output logic [DSC_W-1:0]         out_dsc,
    output logic [CIDX_W-1:0]        out_cidx,
    output logic                     out_vld,
    input  logic                     out_rdy,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   fill_lvl,
    output logic [31:0]              perf_push_cnt,
    output logic [31:0]              perf_stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DSC_W + CIDX_W;
    out_st_t       st, st_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   cnt, ram_cnt;
    logic          rdy_en, push, pop, load, ram_empty, ram_rd, byp, wr_en, fwd_sel;
    logic [EW-1:0] in_ent, rd_data, fwd_q, head, out_q;
    assign in_ent     = {in_dsc, in_cidx};
    assign out_vld    = st == ST_VALID;
    assign in_rdy     = rdy_en && (cnt < (AW+1)'(DEPTH)) && !flush;
    assign push       = in_vld && in_rdy;
    assign pop        = out_vld && out_rdy;
    assign ram_cnt    = cnt - {{AW{1'b0}}, out_vld};
    assign ram_empty  = ram_cnt == '0;
    // The output register reloads whenever it is empty or being drained; it takes the
    // RAM head if one exists, otherwise the incoming entry goes straight past the RAM.
    assign load       = !out_vld || pop;
    assign ram_rd     = load && !ram_empty;
    assign byp        = load && ram_empty && push;
    assign wr_en      = push && !byp;
    assign rd_ptr_nxt = flush ? '0 : rd_ptr + AW'(ram_rd);
    // The RAM is read at the pointer it will hold after this edge; if that slot is
    // written on the same edge, the read returns stale data, so the written entry is
    // kept aside for one cycle and used instead.
    assign head       = fwd_sel ? fwd_q : rd_data;
    assign out_dsc    = out_q[EW-1:CIDX_W];
    assign out_cidx   = out_q[CIDX_W-1:0];
    assign fill_lvl   = cnt;
    dsc_byp_fifo_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk     (axi_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_ent),
        .rd_addr (rd_ptr_nxt),
        .rd_data (rd_data)
    );
    always_comb begin
        st_nxt = flush ? ST_EMPTY
               : (st == ST_EMPTY) ? (push ? ST_VALID : ST_EMPTY)
               : (pop && ram_empty && !push) ? ST_EMPTY : ST_VALID;
    end
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) st <= ST_EMPTY;
        else st <= st_nxt;
    end
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rdy_en  <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            fwd_sel <= 1'b0;
            fwd_q   <= '0;
            out_q   <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                fwd_sel <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr + AW'(wr_en);
                rd_ptr  <= rd_ptr_nxt;
                cnt     <= cnt + (AW+1)'(push) - (AW+1)'(pop);
                fwd_sel <= wr_en && (wr_ptr == rd_ptr_nxt);
                if (wr_en) fwd_q <= in_ent;
                if (ram_rd) out_q <= head;
                else if (byp) out_q <= in_ent;
            end
        end
    end
`ifdef DSC_BYP_IN_PERF_CNT_EN
    logic [31:0] push_cnt_q, stall_cnt_q;
    // Saturating counters; flush leaves them alone, only reset clears them.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            push_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push && push_cnt_q != '1) push_cnt_q <= push_cnt_q + 32'd1;
            if (out_vld && !out_rdy && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign perf_push_cnt  = push_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_push_cnt  = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: doc/dsc_byp_in_fifo.md
DSC_BYP_IN_FIFO -- requirements
Module: dsc_byp_in_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning descriptor entries stored; power of two, 4..256.
REQ-002 SHALL have parameter DSC_W, default 256, meaning descriptor width in bits.
REQ-003 SHALL have port axi_aclk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port axi_aresetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_dsc  input  DSC_W  descriptor from the upstream producer.
REQ-006 SHALL have port in_cidx  input  16  consumer index paired with in_dsc.
REQ-007 SHALL have port in_vld  input  1  upstream valid.
REQ-008 SHALL have port in_rdy  output  1  block can accept.
REQ-009 SHALL have port out_dsc  output  DSC_W  descriptor to the bypass-in interface (master side).
REQ-010 SHALL have port out_cidx  output  16  cidx to the bypass-in interface.
REQ-011 SHALL have port out_vld  output  1  bypass-in valid.
REQ-012 SHALL have port out_rdy  input  1  bypass-in ready from the DMA.
REQ-013 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-014 SHALL have port fill_lvl  output  $clog2(DEPTH)+1  entries held, including the output register.
REQ-015 SHALL have port perf_push_cnt  output  32  accepted-descriptor count (see Configuration).
REQ-016 SHALL have port perf_stall_cnt  output  32  cycles with out_vld=1 and out_rdy=0 (see Configuration).

Function
REQ-017 SHALL accept an entry on any edge where in_vld and in_rdy are both 1, and present one entry on any edge where out_vld and out_rdy are both 1.
REQ-018 SHALL drive in_rdy = 1 iff fill_lvl < DEPTH and flush = 0; in_rdy SHALL NOT depend combinationally on out_rdy.
REQ-019 SHALL drive out_dsc, out_cidx and out_vld from registers; first-word fall-through; an entry written into an empty block appears at out_vld on the next edge (1-cycle latency).
REQ-020 SHALL hold out_dsc and out_cidx stable, and keep out_vld at 1, while out_vld=1 and out_rdy=0.
REQ-021 SHALL preserve strict FIFO order; dsc and cidx SHALL travel as one unit.
REQ-022 SHALL, on a simultaneous push and pop, leave fill_lvl unchanged; at fill_lvl = DEPTH, a pop frees a slot visible as in_rdy = 1 on the following cycle only.
REQ-023 SHALL use read and write pointers of width $clog2(DEPTH) that wrap modulo DEPTH; fill_lvl SHALL never exceed DEPTH or underflow.
REQ-024 SHALL, when flush = 1 on an edge, zero the pointers and fill_lvl and clear out_vld, ignoring any push or pop on that edge.
REQ-025 SHALL track the output stage with two states: EMPTY (out_vld = 0) and VALID (out_vld = 1).
- EMPTY -> VALID when storage is non-empty.
- VALID -> EMPTY on a pop when the remaining storage is empty.
- Any state -> EMPTY on flush.

Reset
REQ-026 SHALL, while axi_aresetn = 0, force in_rdy = 0, out_vld = 0, out_dsc = 0, out_cidx = 0, fill_lvl = 0, both perf counters = 0, pointers = 0.
REQ-027 SHALL raise in_rdy on the first edge after reset deasserts; storage RAM contents need no reset.
REQ-028 SHALL, on reset mid-transfer, discard all stored entries; no partial descriptor is ever presented.

Configuration
REQ-029 SHALL compile the performance counters only when DSC_BYP_IN_PERF_CNT_EN is defined.
- With the macro: 32-bit counters that saturate at 0xFFFFFFFF; flush does not clear them.
- Without the macro: both ports tie to 0 and no counter flops exist.

Structure
REQ-030 SHALL place in the shared dma package: the cidx width constant (16), the default descriptor width constant (256), and a packed descriptor-entry typedef {dsc, cidx}.
REQ-031 SHALL instantiate exactly one sub-module, dsc_byp_fifo_ram: simple dual-port storage of DEPTH x (DSC_W+16) bits, registered read, write-first not required.

Verification
REQ-032 Bench SHALL cover: after reset, push 3 descriptors with cidx 1,2,3 and out_rdy = 1 -> outputs cidx 1,2,3 in order, first out_vld one cycle after the first push.
REQ-033 Bench SHALL cover: out_rdy = 0 and 16 pushes with DEPTH = 16 -> fill_lvl = 16, in_rdy = 0, out_dsc stable; one pop -> in_rdy = 1 on the next cycle.
REQ-034 Bench SHALL cover: continuous push and pop for 40 entries with DEPTH = 16 (pointer wrap) -> all 40 cidx values in order, fill_lvl constant in steady state.
REQ-035 Bench SHALL cover: flush asserted with fill_lvl = 5 and simultaneous in_vld = 1 -> next cycle fill_lvl = 0, out_vld = 0, pushed entry dropped.
REQ-036 Bench SHALL cover: axi_aresetn pulsed low with fill_lvl = 7 -> all outputs 0 immediately (asynchronous); later pushes start fresh.
REQ-037 Bench SHALL cover: with DSC_BYP_IN_PERF_CNT_EN defined, 10 pushes and 4 stall cycles -> perf_push_cnt = 10, perf_stall_cnt = 4; without the macro both read 0.
